// File: rtl/switch_event_accumulator.sv
// Switch event accumulator: debounced presses add channel-weighted steps to a
// saturating or wrapping total, mirrored on three active-low 7-segment digits.

module sea_debounce #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_deb
);
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_deb;

  // Any sample agreeing with the debounced bit restarts the run count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sw};
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb = r_deb;
endmodule

module switch_event_accumulator #(
  parameter int N_CH = 4,
  parameter int W    = 10,
  parameter int DEB  = 4,
  parameter int STEP = 4,
  parameter int MAX  = 220,
  parameter int WRAP = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic [N_CH-1:0] sw,
  output logic [W-1:0]    acc,
  output logic            evt,
  output logic            ovf,
  output logic            busy,
  output logic [6:0]      hex2,
  output logic [6:0]      hex1,
  output logic [6:0]      hex0
);
  localparam int W1  = W + 1;
  localparam int CNW = $clog2(W + 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  logic [N_CH-1:0] w_deb;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sea_debounce #(.DEB(DEB)) u_deb (
      .clk   (clk),
      .reset (reset),
      .i_sw  (sw[g]),
      .o_deb (w_deb[g])
    );
  end

  // Lowest-numbered active channel sets the weight; higher ones are ignored.
  logic [W-1:0] w_inc;
  always_comb begin
    w_inc = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (w_deb[i]) w_inc = W'(STEP * (i + 1));
  end

  typedef enum logic {E_IDLE, E_HELD} ev_st_t;
  ev_st_t r_ev_st;
  logic   r_evt;
  logic   w_take;

  assign w_take = (r_ev_st == E_IDLE) && (|w_deb);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ev_st <= E_IDLE;
      r_evt   <= 1'b0;
    end else begin
      r_evt <= w_take;
      case (r_ev_st)
        E_IDLE:  if (|w_deb)  r_ev_st <= E_HELD;
        E_HELD:  if (~|w_deb) r_ev_st <= E_IDLE;
        default: r_ev_st <= E_IDLE;
      endcase
    end
  end

  logic [W-1:0] r_acc;
  logic         r_ovf;
  logic         r_chg;
  logic [W:0]   w_sum;
  logic [W-1:0] w_acc_nxt;
  logic         w_ovf_nxt;

  always_comb begin
    w_sum     = {1'b0, r_acc} + {1'b0, w_inc};
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (clr) begin
      w_acc_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (w_take) begin
      if (w_sum > W1'(MAX)) begin
        w_ovf_nxt = 1'b1;
        w_acc_nxt = (WRAP != 0) ? W'(w_sum - W1'(MAX + 1)) : W'(MAX);
      end else begin
        w_acc_nxt = w_sum[W-1:0];
      end
    end
  end

  // r_chg marks the cycle after any change of acc; it kicks the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      r_chg <= (w_acc_nxt != r_acc);
    end
  end

  typedef enum logic [1:0] {C_IDLE, C_CONV, C_DONE} cv_st_t;
  cv_st_t         r_cv_st;
  logic [CNW-1:0] r_bit;
  logic [W-1:0]   r_bin;
  logic [11:0]    r_bcd;
  logic           r_pend;
  logic           r_busy;
  logic [6:0]     r_hex2, r_hex1, r_hex0;
  logic [11:0]    w_adj;

  assign w_adj = add3(r_bcd);

  // DONE restarts straight into CONV when a change arrived meanwhile, so busy
  // never drops between back-to-back conversions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cv_st <= C_IDLE;
      r_bit   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_hex2  <= SEG_ZERO;
      r_hex1  <= SEG_ZERO;
      r_hex0  <= SEG_ZERO;
    end else begin
      case (r_cv_st)
        C_IDLE: begin
          if (r_chg || r_pend) begin
            r_bin   <= r_acc;
            r_bcd   <= '0;
            r_bit   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
            r_cv_st <= C_CONV;
          end
        end
        C_CONV: begin
          if (r_chg) r_pend <= 1'b1;
          r_bcd <= {w_adj[10:0], r_bin[W-1]};
          r_bin <= {r_bin[W-2:0], 1'b0};
          r_bit <= r_bit + CNW'(1);
          if (r_bit == CNW'(W - 1)) r_cv_st <= C_DONE;
        end
        C_DONE: begin
          r_hex2 <= seg7(r_bcd[11:8]);
          r_hex1 <= seg7(r_bcd[7:4]);
          r_hex0 <= seg7(r_bcd[3:0]);
          if (r_chg || r_pend) begin
            r_bin   <= r_acc;
            r_bcd   <= '0;
            r_bit   <= '0;
            r_pend  <= 1'b0;
            r_cv_st <= C_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_cv_st <= C_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_cv_st <= C_IDLE;
        end
      endcase
    end
  end

  assign acc  = r_acc;
  assign evt  = r_evt;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign hex2 = r_hex2;
  assign hex1 = r_hex1;
  assign hex0 = r_hex0;
endmodule

// File: tb/tb_switch_event_accumulator.sv
// Directed presses against an evt/hex scoreboard, with a WRAP=1 twin sharing
// the switch stimulus.
module tb_switch_event_accumulator;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clr = 1'b0;
  logic         clr2 = 1'b0;
  logic [3:0]   sw = '0;
  logic [W-1:0] acc, acc2;
  logic         evt, evt2, ovf, ovf2, busy, busy2;
  logic [6:0]   hex2, hex1, hex0, wh2, wh1, wh0;
  logic [31:0]  hexw;

  always #5 clk = ~clk;

  switch_event_accumulator dut (
    .clk(clk), .reset(reset), .clr(clr), .sw(sw), .acc(acc), .evt(evt),
    .ovf(ovf), .busy(busy), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  switch_event_accumulator #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .clr(clr2), .sw(sw), .acc(acc2), .evt(evt2),
    .ovf(ovf2), .busy(busy2), .hex2(wh2), .hex1(wh1), .hex0(wh0)
  );

  assign hexw = {11'b0, hex2, hex1, hex0};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Patterns written as abcdefg strings, then reversed so bit 0 is segment a.
  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    logic [6:0] r;
    case (d)
      0: s = 7'b0000001;
      1: s = 7'b1001111;
      2: s = 7'b0010010;
      3: s = 7'b0000110;
      4: s = 7'b1001100;
      5: s = 7'b0100100;
      6: s = 7'b0100000;
      7: s = 7'b0001111;
      8: s = 7'b0000000;
      9: s = 7'b0001100;
      default: s = 7'b1111111;
    endcase
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [31:0] hex_of(input int v);
    return {11'b0, seg(v / 100), seg((v / 10) % 10), seg(v % 10)};
  endfunction

  int m_acc = 0, m_ovf = 0, m_acc2 = 0, m_ovf2 = 0;
  int q_evt[$];
  logic [31:0] q_hex[$];
  int n_evt = 0, n_fall = 0;
  logic prev_busy = 1'b0;
  int mon_e;

  task automatic model_press(input logic [3:0] v, input bit with_clr);
    int k, inc;
    k = 0;
    while (k < 3 && !v[k]) k++;
    inc = 4 * (k + 1);
    if (with_clr) begin
      m_acc = 0; m_ovf = 0;
    end else if (m_acc + inc > 220) begin
      m_acc = 220; m_ovf = 1;
    end else m_acc += inc;
    if (m_acc2 + inc > 220) begin
      m_acc2 = m_acc2 + inc - 221; m_ovf2 = 1;
    end else m_acc2 += inc;
    q_evt.push_back((m_ovf << 16) | m_acc);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (evt) begin
        n_evt++;
        if (q_evt.size() == 0) chk("evt_unexpected", 1, 0);
        else begin
          mon_e = q_evt.pop_front();
          chk("evt_acc", 32'(acc), mon_e & 'hffff);
          chk("evt_ovf", 32'(ovf), mon_e >> 16);
        end
      end
      if (prev_busy && !busy) begin
        n_fall++;
        if (q_hex.size() == 0) chk("hex_unexpected", 1, 0);
        else chk("hex", hexw, q_hex.pop_front());
      end
    end
    prev_busy <= busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; sw = '0; clr = 1'b0;
    tick(2);
    reset = 1'b0;
    m_acc = 0; m_ovf = 0; m_acc2 = 0; m_ovf2 = 0;
    q_evt.delete(); q_hex.delete();
  endtask

  task automatic wait_evt(output int lat, input int bound);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick(1);
      if (evt) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat, e0, f0, bh, old;
    tick(2);
    reset = 1'b0;

    chk("rst_acc", 32'(acc), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hex", hexw, hex_of(0));

    // Single press: latency and conversion timing.
    model_press(4'b0001, 0);
    q_hex.push_back(hex_of(m_acc));
    sw = 4'b0001;
    wait_evt(lat, 20);
    chk("s1_evt_lat", lat, 7);
    chk("s1_acc", 32'(acc), 4);
    tick(1);
    chk("s1_evt_once", 32'(evt), 0);
    tick(2);
    sw = '0;
    tick(8);
    chk("s1_hex_old", hexw, hex_of(0));
    chk("s1_busy", 32'(busy), 1);
    tick(1);
    chk("s1_hex_new", hexw, hex_of(4));
    tick(10);

    // Glitch of 3 cycles must not register.
    do_reset();
    e0 = n_evt;
    sw = 4'b0001;
    tick(3);
    sw = '0;
    tick(20);
    chk("glitch_evt", n_evt - e0, 0);
    chk("glitch_acc", 32'(acc), 0);

    // Two quick presses, two bits set: conversions coalesce, busy stays high.
    f0 = n_fall;
    model_press(4'b1100, 0);
    model_press(4'b1100, 0);
    q_hex.push_back(hex_of(m_acc));
    sw = 4'b1100; tick(4);
    sw = '0;      tick(5);
    sw = 4'b1100; tick(15);
    sw = '0;      tick(25);
    chk("coal_falls", n_fall - f0, 1);
    chk("coal_acc", 32'(acc), 24);

    // Saturation on dut, wrap on the twin.
    do_reset();
    for (int p = 1; p <= 55; p++) begin
      old = m_acc;
      model_press(4'b1010, 0);
      if (m_acc != old) q_hex.push_back(hex_of(m_acc));
      sw = 4'b1010; tick(10);
      sw = '0;      tick(16);
      chk("wrap_acc", 32'(acc2), m_acc2);
      chk("wrap_ovf", 32'(ovf2), m_ovf2);
      if (p == 28) begin
        chk("wrap_216_plus8", 32'(acc2), 3);
        chk("wrap_216_ovf", 32'(ovf2), 1);
      end
    end
    chk("sat_acc", 32'(acc), 220);
    chk("sat_ovf", 32'(ovf), 1);

    // clr on the same edge as evt: clr wins, evt still pulses.
    model_press(4'b0001, 1);
    q_hex.push_back(hex_of(m_acc));
    sw = 4'b0001;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_evt", 32'(evt), 1);
    chk("clr_acc", 32'(acc), 0);
    chk("clr_ovf", 32'(ovf), 0);
    tick(4);
    sw = '0;
    tick(20);

    // Reset while a conversion runs with a request pending.
    model_press(4'b0001, 0);
    q_hex.push_back(hex_of(m_acc));
    sw = 4'b0001; tick(10);
    sw = '0;      tick(16);
    model_press(4'b0100, 0);
    model_press(4'b0100, 0);
    sw = 4'b0100; tick(4);
    sw = '0;      tick(5);
    sw = 4'b0100; tick(8);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_acc", 32'(acc), 28);
    reset = 1'b1;
    sw = '0;
    tick(1);
    chk("rst_conv_busy", 32'(busy), 0);
    chk("rst_conv_hex", hexw, hex_of(0));
    chk("rst_conv_acc", 32'(acc), 0);
    chk("rst_conv_qevt", q_evt.size(), 0);
    reset = 1'b0;
    m_acc = 0; m_ovf = 0; m_acc2 = 0; m_ovf2 = 0;
    q_hex.delete();
    bh = 0;
    repeat (30) begin
      tick(1);
      if (busy) bh++;
    end
    chk("rst_pend_dropped", bh, 0);
    chk("rst_hex_hold", hexw, hex_of(0));

    chk("end_qevt", q_evt.size(), 0);
    chk("end_qhex", q_hex.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/switch_event_accumulator.md
SWITCH_EVENT_ACCUMULATOR -- requirements
Module: switch_event_accumulator

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- N_CH, 4: number of switch channels.
- W, 10: accumulator width; W SHALL be large enough to hold MAX+N_CH*STEP.
- DEB, 4: debounce length in clk cycles; DEB >= 1.
- STEP, 4: base increment weight.
- MAX, 220: accumulator ceiling; MAX <= 999.
- WRAP, 0: 0 = saturate at MAX, 1 = wrap modulo MAX+1.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of accumulator and ovf.
- sw  in  N_CH  asynchronous switch inputs.
- acc  out  W  accumulated value.
- evt  out  1  one-cycle pulse per accepted switch event.
- ovf  out  1  sticky flag: the ceiling was exceeded.
- busy  out  1  BCD conversion in progress.
- hex2, hex1, hex0  out  7 each  active-low 7-segment patterns for hundreds, tens and units; bit 0 = segment a ... bit 6 = segment g.

Function
REQ-003 Each sw bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-004 Debounce: per channel, the debounced bit SHALL take the synchronised value after DEB consecutive cycles in which the synchronised value differs from the debounced bit; any agreeing sample SHALL reset that channel's counter.
REQ-005 Event FSM states SHALL be IDLE and HELD. IDLE->HELD occurs when the debounced vector is nonzero. HELD->IDLE occurs when the debounced vector is all-zero.
REQ-006 evt SHALL be high for exactly the one cycle following the IDLE->HELD transition. Total latency from a clean sw 0->1 change to evt is DEB+3 clock edges.
REQ-007 On evt, the channel index k SHALL be the lowest-numbered set debounced bit; additional set bits SHALL be ignored; increment = STEP*(k+1).
REQ-008 acc SHALL update on the same edge that asserts evt.
REQ-009 If acc+increment > MAX: with WRAP=0, acc = MAX; with WRAP=1, acc = acc+increment-(MAX+1). In both cases ovf SHALL be set.
REQ-010 clr SHALL set acc=0 and ovf=0 on the next edge. If clr and an evt increment coincide, clr SHALL win, and evt SHALL still pulse.
REQ-011 Conversion FSM states SHALL be IDLE, CONV and DONE.
- IDLE->CONV: on the cycle after acc changes, acc is captured.
- CONV: W shift-add-3 (double-dabble) cycles.
- DONE: one cycle; hex2/hex1/hex0 load the new digits; then IDLE.
REQ-012 busy SHALL be high in CONV and DONE. The latency from an acc change to the hex update SHALL be W+2 cycles.
REQ-013 If acc changes while busy, a pending flag SHALL be set, and a new conversion SHALL start in the cycle after DONE. Further changes SHALL coalesce into that single pending request.
REQ-014 Digit patterns (abcdefg, active-low) SHALL be: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100. Any non-BCD value SHALL display 1111111.
REQ-015 Leading zeros SHALL be displayed, not blanked.

Reset
REQ-016 While reset is high, the following SHALL hold on the next edge:
- synchronisers, debounce counters and debounced bits = 0.
- Event FSM = IDLE; evt = 0.
- acc = 0; ovf = 0.
- Conversion FSM = IDLE; busy = 0; pending = 0.
- hex2/hex1/hex0 = pattern for 0.
REQ-017 Reset asserted mid-conversion SHALL abort the conversion, discard any pending request, and restore the REQ-016 values.
REQ-018 Reset SHALL take priority over clr and over every event.

Verification
REQ-019 With default parameters, the bench SHALL cover the following directed scenarios:
- sw=0001 held 10 cycles after reset -> evt pulses once at edge DEB+3=7; acc=4; hex=0,0,4 after 12 more cycles.
- sw bit0 toggles with a glitch shorter than 4 cycles -> no evt; acc stays 0.
- sw=1010 pressed and released 55 times (increment 8 each) -> acc saturates at 220 with ovf=1; with WRAP=1 at acc=216, one press gives acc=3 and ovf=1.
- Two presses whose acc changes fall within 12 cycles -> busy is high continuously across two conversions; final hex matches the final acc.
- clr coincident with evt -> acc=0, ovf=0, evt=1 in that cycle.
- reset during CONV -> next cycle busy=0, hex=0,0,0, acc=0; the pending conversion is dropped.
